// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the multi-word add/subtract sequencer.
//   seq_state_t : sequencer FSM state
//     FIRST -- the next accepted word starts a new operation
//     CHAIN -- the next accepted word continues an operation; its carry-in
//              comes from the carry register
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic {
    FIRST = 1'b0,
    CHAIN = 1'b1
  } seq_state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// -----------------------------------------------------------------------------
// carry_lookahead_adder
// Block carry-lookahead adder: sum = a + b + cin.
// Block generate/propagate terms produce each block's carry-in directly.
// Inside a block, the carries are formed from that block carry-in.
//
// Parameters
//   DATA_WIDTH : operand width (a multiple of BLOCK_SIZE)
//   BLOCK_SIZE : bits per lookahead block
// Ports
//   a, b    : operands
//   cin     : carry into bit 0
//   sum     : a + b + cin, truncated to DATA_WIDTH
//   cout    : carry out of the most-significant bit
//   msb_cin : carry into the most-significant bit (used for signed overflow)
// -----------------------------------------------------------------------------
module carry_lookahead_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  cin,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  msb_cin
);

  localparam int NB = DATA_WIDTH / BLOCK_SIZE;

  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] p;
  logic [NB-1:0]         bg;
  logic [NB-1:0]         bp;
  logic [NB:0]           bc;
  logic                  cc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    bg      = '0;
    bp      = '0;
    bc      = '0;
    sum     = '0;
    msb_cin = 1'b0;
    cc      = 1'b0;

    // Block-level generate/propagate.
    for (int k = 0; k < NB; k++) begin
      bg[k] = 1'b0;
      bp[k] = 1'b1;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        bg[k] = g[k*BLOCK_SIZE+i] | (p[k*BLOCK_SIZE+i] & bg[k]);
        bp[k] = bp[k] & p[k*BLOCK_SIZE+i];
      end
    end

    // Lookahead across blocks.
    bc[0] = cin;
    for (int k = 0; k < NB; k++) begin
      bc[k+1] = bg[k] | (bp[k] & bc[k]);
    end

    // Bit sums.
    for (int k = 0; k < NB; k++) begin
      cc = bc[k];
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        sum[k*BLOCK_SIZE+i] = p[k*BLOCK_SIZE+i] ^ cc;
        if (k*BLOCK_SIZE+i == DATA_WIDTH-1) msb_cin = cc;
        cc = g[k*BLOCK_SIZE+i] | (p[k*BLOCK_SIZE+i] & cc);
      end
    end
  end

  assign cout = bc[NB];

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// multiword_addsub_sequencer
// Adds or subtracts arbitrarily long operands presented one word per
// transfer, least-significant word first. The carry is chained between words
// through a carry register. Each result word is registered, so a result
// appears one cycle after its input word is accepted.
//
// Handshake (both sides): a word transfers on a rising clk edge where valid
// and ready are both high. valid, once raised, is not withdrawn and its
// payload is not changed until the transfer. ready may depend combinationally
// on the downstream ready (in_ready = !out_valid || out_ready).
//
// Parameters
//   DATA_WIDTH : operand word width (multiple of BLOCK_SIZE)
//   BLOCK_SIZE : lookahead block size of the adder core
//   MAX_WORDS  : longest operation; a longer one is cut at MAX_WORDS words
// Ports
//   clk, rst           : clock, synchronous active-high reset
//   in_valid, in_ready : input handshake
//   A, B               : operand words
//   sub                : 1 = A-B (sampled on an operation's first word only)
//   in_last            : marks the most-significant word
//   out_valid, out_ready : output handshake
//   S                  : result word
//   out_last, out_idx  : last-word flag, word index within the operation
//   CF, OF             : carry-out and signed overflow (valid with out_last)
//   err                : one-cycle pulse when an operation was truncated
//   dbg_state          : current FSM state
// Optional feature (macro ADDSUB_OVF_STICKY_EN)
//   ovf_sticky : set by any completed operation with OF=1
//   ovf_clr    : clears ovf_sticky; a simultaneous set wins
// -----------------------------------------------------------------------------
module multiword_addsub_sequencer
  import addsub_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int BLOCK_SIZE = 4,
  parameter  int MAX_WORDS  = 8,
  localparam int IDX_W      = $clog2(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  sub,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  CF,
  output logic                  OF,
  output logic                  err,
`ifdef ADDSUB_OVF_STICKY_EN
  output logic                  ovf_sticky,
  input  logic                  ovf_clr,
`endif
  output seq_state_t            dbg_state
);

  seq_state_t            state;
  seq_state_t            state_next;
  logic                  carry_q;
  logic                  op_q;
  logic [IDX_W-1:0]      cnt_q;

  logic                  accept;
  logic                  sub_eff;
  logic                  cin;
  logic                  trunc;
  logic                  last_eff;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH-1:0] sum;
  logic                  cout;
  logic                  msb_cin;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // The operation type is taken from the first word and held for the rest.
  assign sub_eff  = (state == FIRST) ? sub : op_q;
  // Subtraction is A + ~B + 1; the +1 enters as the first word's carry-in.
  assign cin      = (state == FIRST) ? sub_eff : carry_q;
  assign b_eff    = sub_eff ? ~B : B;

  // The word at index MAX_WORDS-1 always closes the operation.
  assign trunc    = (cnt_q == IDX_W'(MAX_WORDS - 1));
  assign last_eff = in_last || trunc;

  carry_lookahead_adder #(
    .DATA_WIDTH (DATA_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_cla (
    .a       (A),
    .b       (b_eff),
    .cin     (cin),
    .sum     (sum),
    .cout    (cout),
    .msb_cin (msb_cin)
  );

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = last_eff ? FIRST : CHAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FIRST;
    else     state <= state_next;
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q   <= 1'b0;
      op_q      <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      S         <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      CF        <= 1'b0;
      OF        <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Truncation is an error only when the word did not already end the op.
      err <= accept && trunc && !in_last;
      if (accept) begin
        out_valid <= 1'b1;
        S         <= sum;
        out_last  <= last_eff;
        out_idx   <= cnt_q;
        CF        <= cout;
        OF        <= cout ^ msb_cin;
        op_q      <= sub_eff;
        if (last_eff) begin
          carry_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          carry_q <= cout;
          cnt_q   <= cnt_q + IDX_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ADDSUB_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (accept && last_eff && (cout ^ msb_cin)) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multiword_addsub_sequencer
// Directed bench for multiword_addsub_sequencer (DATA_WIDTH=16, BLOCK_SIZE=4,
// MAX_WORDS=8). Covers ovf_sticky as well when ADDSUB_OVF_STICKY_EN is defined.
// -----------------------------------------------------------------------------
module tb_multiword_addsub_sequencer;
  import addsub_pkg::*;

  localparam int DW = 16;
  localparam int IW = 3;
  localparam int EW = DW + 1 + IW + 3;  // {s, last, idx, cf, of, err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          sub;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] S;
  logic          out_last;
  logic [IW-1:0] out_idx;
  logic          CF;
  logic          OF;
  logic          err;
  seq_state_t    dbg_state;
`ifdef ADDSUB_OVF_STICKY_EN
  logic          ovf_sticky;
  logic          ovf_clr;
`endif

  multiword_addsub_sequencer #(
    .DATA_WIDTH (16),
    .BLOCK_SIZE (4),
    .MAX_WORDS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .sub        (sub),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .S          (S),
    .out_last   (out_last),
    .out_idx    (out_idx),
    .CF         (CF),
    .OF         (OF),
    .err        (err),
`ifdef ADDSUB_OVF_STICKY_EN
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_obs;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [EW-1:0] pack_exp(input logic [DW-1:0] s, input logic last,
                                             input logic [IW-1:0] idx, input logic cf,
                                             input logic of, input logic e);
    return {s, last, idx, cf, of, e};
  endfunction

  // CF/OF are only meaningful on the last word, so they are masked elsewhere.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      mon_obs = {S, out_last, out_idx, CF, OF, err};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL out_word: got unexpected word 0x%0h, wanted none", mon_obs);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_mask = mon_exp[IW+3] ? {EW{1'b1}} : ~EW'(6);
        check("out_word{s,last,idx,cf,of,err}", 32'(mon_obs & mon_mask), 32'(mon_exp & mon_mask));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic s, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    A = a; B = b; sub = s; in_last = l; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for 100 cycles, wanted 1");
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          sub;
    logic          last;
    logic [DW-1:0] s;
    logic          e_last;
    logic [IW-1:0] idx;
    logic          cf;
    logic          of;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sb,
                         input logic l, input logic [DW-1:0] s, input logic el,
                         input logic [IW-1:0] idx, input logic cf, input logic of);
    vec_t v;
    v = '{a, b, sb, l, s, el, idx, cf, of};
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
`ifdef ADDSUB_OVF_STICKY_EN
    ovf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_S",         32'(S),         32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_idx",   32'(out_idx),   32'd0);
    check("rst_CF",        32'(CF),        32'd0);
    check("rst_OF",        32'(OF),        32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_state",     32'(dbg_state), 32'(FIRST));
`ifdef ADDSUB_OVF_STICKY_EN
    check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
`endif
    rst = 1'b0;

    //       a        b        sub   last  s        e_last idx   cf    of
    // 2-word add 0x0001_FFFF + 0x0000_0001 = 0x0002_0000
    add_vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0);
    add_vec(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 3'd1, 1'b0, 1'b0);
    // 1-word 5 - 7 = -2, borrow -> CF=0
    add_vec(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b1, 3'd0, 1'b0, 1'b0);
    // 1-word 0x7FFF + 1 overflows
    add_vec(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 3'd0, 1'b0, 1'b1);
    // 1-word -32768 - 1 overflows, no borrow -> CF=1
    add_vec(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 3'd0, 1'b1, 1'b1);
    // 3-word 0x0001_0000_0000 - 1 = 0x0000_FFFF_FFFF; sub low on later words
    add_vec(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 3'd0, 1'b0, 1'b0);
    add_vec(16'h0000, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 3'd1, 1'b0, 1'b0);
    add_vec(16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 3'd2, 1'b1, 1'b0);
    // 2-word add with carry; sub high on word 1 must be ignored
    add_vec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0);
    add_vec(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0001, 1'b1, 3'd1, 1'b0, 1'b0);
    // 1-word -1 + -1 = -2, carry out, no overflow
    add_vec(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b1, 3'd0, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      exp_q.push_back(pack_exp(tbl[i].s, tbl[i].e_last, tbl[i].idx, tbl[i].cf, tbl[i].of, 1'b0));
      send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].last);
    end
    idle();

`ifdef ADDSUB_OVF_STICKY_EN
    @(negedge clk);
    check("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_sticky_clr", 32'(ovf_sticky), 32'd0);
`endif

    // Backpressure: hold out_ready low while a second word waits.
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_q.push_back(pack_exp(16'h3333, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
    send(16'h1111, 16'h2222, 1'b0, 1'b1);
    @(negedge clk);
    A = 16'h00FF; B = 16'h0001; sub = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_S",         32'(S),         32'h3333);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    exp_q.push_back(pack_exp(16'h0100, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pack_exp(16'h0003, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send(16'h0001, 16'h0002, 1'b0, 1'b1);
    idle();

    // Reset after word 0 of a 3-word add whose word 0 carries out.
    exp_q.push_back(pack_exp(16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0));
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_state_chain", 32'(dbg_state), 32'(CHAIN));
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_S",         32'(S),         32'd0);
    check("midrst_out_idx",   32'(out_idx),   32'd0);
    check("midrst_state",     32'(dbg_state), 32'(FIRST));
    rst = 1'b0;
    exp_q.push_back(pack_exp(16'h0001, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
    send(16'h0001, 16'h0000, 1'b0, 1'b1);
    idle();

    // Truncation: 9 words, in_last never high.
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(pack_exp(16'h0110 + 16'(i), (i == 7), (i < 8) ? 3'(i) : 3'd0,
                               1'b0, 1'b0, (i == 7)));
      send(16'h0100 + 16'(i), 16'h0010, 1'b0, 1'b0);
    end
    exp_q.push_back(pack_exp(16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0));
    send(16'h0000, 16'h0000, 1'b0, 1'b1);
    idle();

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
